// File: rtl/fft_mag_peak_if.sv
// Bundle between the FFT core output, the magnitude unit and the spectrum display path.
// Source side is valid-only: a beat transfers on every cycle source_valid is high, there is no ready.
interface fft_mag_peak_if #(
   parameter int DATA_W    = 32,
   parameter int MAX_FRAME = 1024
);
   localparam int BIN_W = $clog2(MAX_FRAME);
   localparam int OUT_W = 2 * DATA_W + 1;

   logic signed [DATA_W-1:0] source_real;
   logic signed [DATA_W-1:0] source_imag;
   logic                     source_sop;
   logic                     source_eop;
   logic                     source_valid;

   logic [OUT_W-1:0]         data_modulus;
   logic                     data_sop;
   logic                     data_eop;
   logic                     data_valid;

   logic                     peak_valid;
   logic [OUT_W-1:0]         peak_mag;
   logic [BIN_W-1:0]         peak_bin;
   logic [BIN_W:0]           frame_len;
   logic                     frame_err;
   logic                     dbg_state;

   modport master (
      output source_real, source_imag, source_sop, source_eop, source_valid,
      input  data_modulus, data_sop, data_eop, data_valid,
      input  peak_valid, peak_mag, peak_bin, frame_len, frame_err, dbg_state
   );

   modport slave (
      input  source_real, source_imag, source_sop, source_eop, source_valid,
      output data_modulus, data_sop, data_eop, data_valid,
      output peak_valid, peak_mag, peak_bin, frame_len, frame_err, dbg_state
   );
endinterface

// File: rtl/fft_mag_peak.sv
// FFT bin magnitude (exact squared or alpha-max-beta-min) in a fixed 3-stage pipeline,
// followed by a per-frame peak tracker reporting the largest bin of each frame.
module fft_mag_peak #(
   parameter int DATA_W    = 32,
   parameter int MODE      = 0,
   parameter int MAX_FRAME = 1024
) (
   input logic          clk,
   input logic          syn_rst,
   fft_mag_peak_if.slave bus
);
   localparam int BIN_W = $clog2(MAX_FRAME);
   localparam int OUT_W = 2 * DATA_W + 1;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(MAX_FRAME - 1);

   typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

   // Two's-complement abs; the most negative input maps to 2^(DATA_W-1) as unsigned.
   logic [DATA_W-1:0] w_abs_re, w_abs_im;
   assign w_abs_re = bus.source_real[DATA_W-1] ? (~bus.source_real + DATA_W'(1)) : bus.source_real;
   assign w_abs_im = bus.source_imag[DATA_W-1] ? (~bus.source_imag + DATA_W'(1)) : bus.source_imag;

   logic [DATA_W-1:0] r_abs_re, r_abs_im;
   logic              r_v1, r_s1, r_e1, r_v2, r_s2, r_e2, r_v3, r_s3, r_e3;
   logic [OUT_W-1:0]  w_mag, r_mag;

   always_ff @(posedge clk) begin
      if (syn_rst) begin
         r_abs_re <= '0;
         r_abs_im <= '0;
         r_v1 <= 1'b0; r_s1 <= 1'b0; r_e1 <= 1'b0;
         r_v2 <= 1'b0; r_s2 <= 1'b0; r_e2 <= 1'b0;
         r_v3 <= 1'b0; r_s3 <= 1'b0; r_e3 <= 1'b0;
         r_mag <= '0;
      end else begin
         r_abs_re <= w_abs_re;
         r_abs_im <= w_abs_im;
         r_v1 <= bus.source_valid;
         r_s1 <= bus.source_sop & bus.source_valid;
         r_e1 <= bus.source_eop & bus.source_valid;
         r_v2 <= r_v1; r_s2 <= r_s1; r_e2 <= r_e1;
         r_v3 <= r_v2; r_s3 <= r_s2; r_e3 <= r_e2;
         r_mag <= w_mag;
      end
   end

   generate
      if (MODE == 1) begin : g_exact
         logic [2*DATA_W-1:0] w_re_ext, w_im_ext, r_p_re, r_p_im;
         assign w_re_ext = {{DATA_W{1'b0}}, r_abs_re};
         assign w_im_ext = {{DATA_W{1'b0}}, r_abs_im};
         always_ff @(posedge clk) begin
            if (syn_rst) begin
               r_p_re <= '0;
               r_p_im <= '0;
            end else begin
               r_p_re <= w_re_ext * w_re_ext;
               r_p_im <= w_im_ext * w_im_ext;
            end
         end
         assign w_mag = {1'b0, r_p_re} + {1'b0, r_p_im};
      end else begin : g_approx
         logic [DATA_W-1:0] r_big, r_small;
         logic [DATA_W:0]   w_est, w_sel;
         always_ff @(posedge clk) begin
            if (syn_rst) begin
               r_big   <= '0;
               r_small <= '0;
            end else begin
               r_big   <= (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
               r_small <= (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;
            end
         end
         // M - M/8 + m/2 with truncating shifts, never allowed below M itself.
         assign w_est = {1'b0, r_big} - {1'b0, r_big >> 3} + {1'b0, r_small >> 1};
         assign w_sel = (w_est > {1'b0, r_big}) ? w_est : {1'b0, r_big};
         assign w_mag = {{(OUT_W-DATA_W-1){1'b0}}, w_sel};
      end
   endgenerate

   state_t           r_state;
   logic [BIN_W-1:0] r_bin, r_peak_idx, r_peak_bin_o;
   logic [OUT_W-1:0] r_peak, r_peak_mag_o;
   logic [BIN_W:0]   r_frame_len;
   logic             r_peak_valid, r_frame_err;

   logic [BIN_W-1:0] w_next_bin, w_new_idx;
   logic [OUT_W-1:0] w_new_peak;
   logic             w_upd;
   assign w_next_bin = r_bin + BIN_W'(1);
   assign w_upd      = r_mag > r_peak;
   assign w_new_peak = w_upd ? r_mag : r_peak;
   assign w_new_idx  = w_upd ? w_next_bin : r_peak_idx;

   always_ff @(posedge clk) begin
      if (syn_rst) begin
         r_state      <= ST_IDLE;
         r_bin        <= '0;
         r_peak       <= '0;
         r_peak_idx   <= '0;
         r_peak_valid <= 1'b0;
         r_peak_mag_o <= '0;
         r_peak_bin_o <= '0;
         r_frame_len  <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_peak_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (r_v3) begin
            if (r_s3) begin
               // A sop always starts a fresh frame; mid-frame it also flags the broken one.
               r_frame_err <= (r_state == ST_IN_FRAME);
               r_bin       <= '0;
               r_peak      <= r_mag;
               r_peak_idx  <= '0;
               if (r_e3) begin
                  r_peak_valid <= 1'b1;
                  r_peak_mag_o <= r_mag;
                  r_peak_bin_o <= '0;
                  r_frame_len  <= (BIN_W+1)'(1);
                  r_state      <= ST_IDLE;
               end else begin
                  r_state <= ST_IN_FRAME;
               end
            end else if (r_state == ST_IDLE) begin
               r_frame_err <= 1'b1;
            end else if (r_bin == LAST_BIN) begin
               r_frame_err <= 1'b1;
               r_state     <= ST_IDLE;
            end else begin
               r_bin      <= w_next_bin;
               r_peak     <= w_new_peak;
               r_peak_idx <= w_new_idx;
               if (r_e3) begin
                  r_peak_valid <= 1'b1;
                  r_peak_mag_o <= w_new_peak;
                  r_peak_bin_o <= w_new_idx;
                  r_frame_len  <= {1'b0, w_next_bin} + (BIN_W+1)'(1);
                  r_state      <= ST_IDLE;
               end
            end
         end
      end
   end

   assign bus.data_modulus = r_mag;
   assign bus.data_sop     = r_s3;
   assign bus.data_eop     = r_e3;
   assign bus.data_valid   = r_v3;
   assign bus.peak_valid   = r_peak_valid;
   assign bus.peak_mag     = r_peak_mag_o;
   assign bus.peak_bin     = r_peak_bin_o;
   assign bus.frame_len    = r_frame_len;
   assign bus.frame_err    = r_frame_err;
   assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench: an exact-mode and an approximate-mode instance fed the same beats,
// with hand-computed magnitudes and frame peaks checked against the outputs.
module tb_fft_mag_peak;
   localparam int DW   = 16;
   localparam int MF   = 16;
   localparam int OW   = 2 * DW + 1;
   localparam int BW   = 4;
   localparam int PK_W = OW + BW + BW + 1;

   logic clk = 1'b0;
   logic syn_rst;
   always #5 clk = ~clk;

   fft_mag_peak_if #(.DATA_W(DW), .MAX_FRAME(MF)) if_ex ();
   fft_mag_peak_if #(.DATA_W(DW), .MAX_FRAME(MF)) if_ap ();

   fft_mag_peak #(.DATA_W(DW), .MODE(1), .MAX_FRAME(MF)) dut_ex (.clk(clk), .syn_rst(syn_rst), .bus(if_ex));
   fft_mag_peak #(.DATA_W(DW), .MODE(0), .MAX_FRAME(MF)) dut_ap (.clk(clk), .syn_rst(syn_rst), .bus(if_ap));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic          v;
      logic          s;
      logic          e;
      logic [OW-1:0] m_ex;
      logic [OW-1:0] m_ap;
   } beat_t;

   beat_t drv, d1, d2, d3;
   logic [PK_W-1:0] pk_ex_q[$];
   logic [PK_W-1:0] pk_ap_q[$];
   int  err_ex = 0, err_ap = 0, exp_err = 0;
   bit  mon_en = 1'b0;

   function automatic logic [PK_W-1:0] pk(input logic [OW-1:0] m, input int bin, input int len);
      return {m, bin[BW-1:0], len[BW:0]};
   endfunction

   // Expected output stream: each driven beat reappears exactly three clocks later.
   always @(posedge clk) begin
      if (syn_rst) begin
         d1 <= '0; d2 <= '0; d3 <= '0;
      end else begin
         d1 <= drv; d2 <= d1; d3 <= d2;
      end
   end

   always @(negedge clk) begin
      logic [PK_W-1:0] p;
      if (mon_en) begin
         check("ex_valid", if_ex.data_valid, d3.v);
         check("ex_sop", if_ex.data_sop, d3.s);
         check("ex_eop", if_ex.data_eop, d3.e);
         check("ap_valid", if_ap.data_valid, d3.v);
         check("ap_sop", if_ap.data_sop, d3.s);
         check("ap_eop", if_ap.data_eop, d3.e);
         if (d3.v) begin
            check("ex_modulus", if_ex.data_modulus, d3.m_ex);
            check("ap_modulus", if_ap.data_modulus, d3.m_ap);
         end
         if (if_ex.frame_err) err_ex++;
         if (if_ap.frame_err) err_ap++;
         if (if_ex.peak_valid) begin
            if (pk_ex_q.size() == 0) check("ex_peak_extra", if_ex.peak_valid, 1'b0);
            else begin
               p = pk_ex_q.pop_front();
               check("ex_peak_mag", if_ex.peak_mag, p[PK_W-1:BW+BW+1]);
               check("ex_peak_bin", if_ex.peak_bin, p[BW+BW:BW+1]);
               check("ex_frame_len", if_ex.frame_len, p[BW:0]);
            end
         end
         if (if_ap.peak_valid) begin
            if (pk_ap_q.size() == 0) check("ap_peak_extra", if_ap.peak_valid, 1'b0);
            else begin
               p = pk_ap_q.pop_front();
               check("ap_peak_mag", if_ap.peak_mag, p[PK_W-1:BW+BW+1]);
               check("ap_peak_bin", if_ap.peak_bin, p[BW+BW:BW+1]);
               check("ap_frame_len", if_ap.frame_len, p[BW:0]);
            end
         end
      end
   end

   task automatic set_in(input int re, input int im, input bit v, input bit s, input bit e);
      if_ex.source_real = re[DW-1:0]; if_ap.source_real = re[DW-1:0];
      if_ex.source_imag = im[DW-1:0]; if_ap.source_imag = im[DW-1:0];
      if_ex.source_valid = v; if_ap.source_valid = v;
      if_ex.source_sop = s;   if_ap.source_sop = s;
      if_ex.source_eop = e;   if_ap.source_eop = e;
   endtask

   task automatic beat(input int re, input int im, input bit s, input bit e,
                       input logic [OW-1:0] m_ex, input logic [OW-1:0] m_ap);
      @(posedge clk); #1;
      set_in(re, im, 1'b1, s, e);
      drv = {1'b1, s, e, m_ex, m_ap};
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         set_in(0, 0, 1'b0, 1'b0, 1'b0);
         drv = '0;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ex_data"}, {if_ex.data_modulus, if_ex.data_sop, if_ex.data_eop, if_ex.data_valid}, 0);
      check({tag, "_ex_peak"}, {if_ex.peak_valid, if_ex.peak_mag, if_ex.peak_bin, if_ex.frame_len, if_ex.frame_err}, 0);
      check({tag, "_ap_data"}, {if_ap.data_modulus, if_ap.data_sop, if_ap.data_eop, if_ap.data_valid}, 0);
      check({tag, "_ap_peak"}, {if_ap.peak_valid, if_ap.peak_mag, if_ap.peak_bin, if_ap.frame_len, if_ap.frame_err}, 0);
   endtask

   task automatic check_errs(input string tag);
      idle(6);
      check({tag, "_ex_errs"}, err_ex, exp_err);
      check({tag, "_ap_errs"}, err_ap, exp_err);
   endtask

   initial begin
      syn_rst = 1'b1;
      set_in(0, 0, 1'b0, 1'b0, 1'b0);
      drv = '0;
      repeat (3) @(posedge clk);
      #1 mon_en = 1'b1;
      @(negedge clk);
      check_zero("reset");
      check("reset_state", if_ex.dbg_state, 1'b0);
      syn_rst = 1'b0;

      // Single-bin frames: exact and approximate magnitudes, including the most negative input.
      beat(3, -4, 1, 1, 33'd25, 33'd5);             pk_ex_q.push_back(pk(33'd25, 0, 1));         pk_ap_q.push_back(pk(33'd5, 0, 1));
      beat(100, -40, 1, 1, 33'd11600, 33'd108);     pk_ex_q.push_back(pk(33'd11600, 0, 1));      pk_ap_q.push_back(pk(33'd108, 0, 1));
      beat(-32768, 0, 1, 1, 33'd1073741824, 33'd32768);
      pk_ex_q.push_back(pk(33'd1073741824, 0, 1));  pk_ap_q.push_back(pk(33'd32768, 0, 1));
      beat(-32768, -32768, 1, 1, 33'd2147483648, 33'd45056);
      pk_ex_q.push_back(pk(33'd2147483648, 0, 1));  pk_ap_q.push_back(pk(33'd45056, 0, 1));
      beat(32767, -32768, 1, 1, 33'd2147418113, 33'd45055);
      pk_ex_q.push_back(pk(33'd2147418113, 0, 1));  pk_ap_q.push_back(pk(33'd45055, 0, 1));
      beat(7, 24, 1, 1, 33'd625, 33'd24);           pk_ex_q.push_back(pk(33'd625, 0, 1));        pk_ap_q.push_back(pk(33'd24, 0, 1));
      check_errs("single");

      // 8-bin frame with two gaps; the tie at bin 3 must not move the peak off bin 1.
      beat(5, 0, 1, 0, 33'd25, 33'd5);
      beat(9, 0, 0, 0, 33'd81, 33'd9);
      beat(2, 0, 0, 0, 33'd4, 33'd2);
      idle(1);
      beat(0, -9, 0, 0, 33'd81, 33'd9);
      beat(7, 0, 0, 0, 33'd49, 33'd7);
      beat(-1, 0, 0, 0, 33'd1, 33'd1);
      idle(1);
      beat(0, 0, 0, 0, 33'd0, 33'd0);
      beat(3, 0, 0, 1, 33'd9, 33'd3);
      pk_ex_q.push_back(pk(33'd81, 1, 8));          pk_ap_q.push_back(pk(33'd9, 1, 8));
      check_errs("frame8");
      check("hold_ap_peak_mag", if_ap.peak_mag, 33'd9);
      check("hold_ex_peak_bin", if_ex.peak_bin, 4'd1);

      // sop inside a running frame restarts it; a stray beat while idle is an error only.
      beat(2, 0, 1, 0, 33'd4, 33'd2);
      beat(4, 0, 0, 0, 33'd16, 33'd4);
      beat(1, 0, 0, 0, 33'd1, 33'd1);
      beat(6, 0, 1, 0, 33'd36, 33'd6);              exp_err++;
      beat(8, 0, 0, 1, 33'd64, 33'd8);
      pk_ex_q.push_back(pk(33'd64, 1, 2));          pk_ap_q.push_back(pk(33'd8, 1, 2));
      idle(2);
      beat(5, 0, 0, 1, 33'd25, 33'd5);              exp_err++;
      check_errs("restart");

      // 17 beats with no eop overflow a 16-bin frame.
      for (int i = 0; i < 17; i++) begin
         beat(i + 1, 0, (i == 0), 0, OW'((i + 1) * (i + 1)), OW'(i + 1));
      end
      exp_err++;
      check_errs("overflow");
      check("overflow_state", if_ap.dbg_state, 1'b0);

      // Reset in the middle of a frame drops it; the following frame reports normally.
      beat(10, 0, 1, 0, 33'd100, 33'd10);
      beat(20, 0, 0, 0, 33'd400, 33'd20);
      beat(30, 0, 0, 0, 33'd900, 33'd30);
      beat(40, 0, 0, 0, 33'd1600, 33'd40);
      @(posedge clk); #1;
      set_in(0, 0, 1'b0, 1'b0, 1'b0);
      drv = '0;
      syn_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("midreset");
      syn_rst = 1'b0;
      beat(1, 0, 1, 0, 33'd1, 33'd1);
      beat(2, 0, 0, 1, 33'd4, 33'd2);
      pk_ex_q.push_back(pk(33'd4, 1, 2));           pk_ap_q.push_back(pk(33'd2, 1, 2));
      check_errs("after_reset");

      check("ex_peaks_left", pk_ex_q.size(), 0);
      check("ap_peaks_left", pk_ap_q.size(), 0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
